// File: rtl/rf_scoreboard.sv
// rf_scoreboard: GPR hazard scoreboard producing decode stall, bypass hints and serialization
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int OUT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       ds_valid,
  input  logic       es_allowin,
  input  logic [4:0] ds_rs,
  input  logic [4:0] ds_rt,
  input  logic       ds_rs_used,
  input  logic       ds_rt_used,
  input  logic [4:0] ds_dest,
  input  logic       ds_dest_we,
  input  logic       ds_late,
  input  logic       ds_serial,
  input  logic       wb_valid,
  input  logic [4:0] wb_dest,
  input  logic       wb_late,
  output logic       ds_stall,
  output logic       ds_issue,
  output logic       rs_inflight,
  output logic       rt_inflight,
  output logic       sb_empty,
  output logic       sb_error
);
  logic [CNT_W-1:0] pend_cnt [NUM_REGS];
  logic [CNT_W-1:0] late_cnt [NUM_REGS];
  logic [CNT_W-1:0] pend_n [NUM_REGS];
  logic [CNT_W-1:0] late_n [NUM_REGS];
  logic [OUT_W-1:0] out_cnt, out_n;
  logic trk, ret, ret_ok, err_n;
  logic rs_late, rt_late, src_hazard, cap_hazard, serial_hazard;
  assign trk = ds_issue & ds_dest_we & (ds_dest != 5'd0);
  assign ret = wb_valid & (wb_dest != 5'd0);
  assign ret_ok = ret & (pend_cnt[wb_dest] != '0);
  // a late write committing in WB this cycle is already forwardable
  assign rs_late = late_cnt[ds_rs] != CNT_W'(wb_valid & wb_late & (wb_dest == ds_rs));
  assign rt_late = late_cnt[ds_rt] != CNT_W'(wb_valid & wb_late & (wb_dest == ds_rt));
  assign src_hazard = (ds_rs_used & (ds_rs != 5'd0) & rs_late) |
                      (ds_rt_used & (ds_rt != 5'd0) & rt_late);
  assign cap_hazard = ds_dest_we & (ds_dest != 5'd0) & (&pend_cnt[ds_dest]) &
                      ~(wb_valid & (wb_dest == ds_dest));
  assign serial_hazard = ds_serial & ((out_cnt != '0) | wb_valid);
  assign ds_stall = ds_valid & (src_hazard | cap_hazard | serial_hazard);
  assign ds_issue = ds_valid & es_allowin & ~ds_stall & ~flush;
  assign rs_inflight = (ds_rs != 5'd0) & (pend_cnt[ds_rs] != '0);
  assign rt_inflight = (ds_rt != 5'd0) & (pend_cnt[ds_rt] != '0);
  assign sb_empty = out_cnt == '0;
  always_comb begin
    pend_n = pend_cnt;
    late_n = late_cnt;
    out_n = out_cnt;
    err_n = ret & ~ret_ok;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (trk && ds_dest == 5'(r) && !(ret_ok && wb_dest == 5'(r))) begin
        if (&pend_cnt[r]) err_n = 1'b1;
        else pend_n[r] = pend_cnt[r] + 1'b1;
      end else if (ret_ok && wb_dest == 5'(r) && !(trk && ds_dest == 5'(r)))
        pend_n[r] = pend_cnt[r] - 1'b1;
      if (trk && ds_late && ds_dest == 5'(r) && !(ret_ok && wb_late && wb_dest == 5'(r))) begin
        if (&late_cnt[r]) err_n = 1'b1;
        else late_n[r] = late_cnt[r] + 1'b1;
      end else if (ret_ok && wb_late && wb_dest == 5'(r) && !(trk && ds_late && ds_dest == 5'(r))) begin
        if (late_cnt[r] == '0) err_n = 1'b1;
        else late_n[r] = late_cnt[r] - 1'b1;
      end
    end
    if (trk & ~ret_ok) begin
      if (&out_cnt) err_n = 1'b1;
      else out_n = out_cnt + 1'b1;
    end else if (ret_ok & ~trk)
      out_n = out_cnt - 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= '{default: '0};
      late_cnt <= '{default: '0};
      out_cnt <= '0;
      sb_error <= 1'b0;
    end else if (flush) begin
      pend_cnt <= '{default: '0};
      late_cnt <= '{default: '0};
      out_cnt <= '0;
    end else begin
      pend_cnt <= pend_n;
      late_cnt <= late_n;
      out_cnt <= out_n;
      sb_error <= sb_error | err_n;
    end
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed stimulus with a queued expectation scoreboard checked by a negedge monitor
module tb_rf_scoreboard;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic ds_valid, es_allowin, ds_rs_used, ds_rt_used, ds_dest_we, ds_late, ds_serial;
  logic [4:0] ds_rs, ds_rt, ds_dest, wb_dest;
  logic wb_valid, wb_late;
  logic ds_stall, ds_issue, rs_inflight, rt_inflight, sb_empty, sb_error;
  typedef struct { string nm; logic [5:0] exp; } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  rf_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .ds_valid(ds_valid), .es_allowin(es_allowin),
    .ds_rs(ds_rs), .ds_rt(ds_rt), .ds_rs_used(ds_rs_used), .ds_rt_used(ds_rt_used),
    .ds_dest(ds_dest), .ds_dest_we(ds_dest_we), .ds_late(ds_late), .ds_serial(ds_serial),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_late(wb_late),
    .ds_stall(ds_stall), .ds_issue(ds_issue), .rs_inflight(rs_inflight),
    .rt_inflight(rt_inflight), .sb_empty(sb_empty), .sb_error(sb_error)
  );
  always #5 clk = ~clk;
  // monitor: compare every expectation queued for this cycle, mid-cycle
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      automatic exp_t e = sb.pop_front();
      automatic logic [5:0] got = {ds_stall, ds_issue, rs_inflight, rt_inflight, sb_empty, sb_error};
      vectors++;
      if (got !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got stall/issue/rsi/rti/empty/err=%b expected %b", e.nm, got, e.exp);
      end
    end
  end
  task automatic idle();
    ds_valid = 0; es_allowin = 1; ds_rs = 0; ds_rt = 0; ds_rs_used = 0; ds_rt_used = 0;
    ds_dest = 0; ds_dest_we = 0; ds_late = 0; ds_serial = 0;
    wb_valid = 0; wb_dest = 0; wb_late = 0; flush = 0;
  endtask
  task automatic ds(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                    input logic we, input logic late, input logic ser);
    ds_valid = 1; ds_rs = rs; ds_rs_used = rs != 0; ds_rt = rt; ds_rt_used = rt != 0;
    ds_dest = dest; ds_dest_we = we; ds_late = late; ds_serial = ser;
  endtask
  task automatic wb(input logic [4:0] d, input logic late);
    wb_valid = 1; wb_dest = d; wb_late = late;
  endtask
  task automatic chk(input string nm, input logic [5:0] e);
    sb.push_back('{nm, e});
  endtask
  task automatic tick();
    @(posedge clk); #1; idle();
  endtask
  initial begin
    idle();
    reset = 1;
    @(posedge clk); #1;
    chk("reset_state", 6'b000010);
    tick();
    reset = 0;
    ds(5, 0, 0, 0, 0, 0);           chk("first_issue", 6'b010010); tick();
    ds(0, 0, 8, 1, 1, 0);           chk("lw_issue", 6'b010010); tick();
    ds(8, 0, 2, 1, 0, 0);           chk("load_use_t1", 6'b101000); tick();
    ds(8, 0, 2, 1, 0, 0);           chk("load_use_t2", 6'b101000); tick();
    ds(8, 0, 2, 1, 0, 0); wb(8, 1); chk("load_use_wb", 6'b011000); tick();
    ds(8, 0, 0, 0, 0, 0); wb(2, 0); chk("late8_cleared", 6'b010000); tick();
    ds(0, 0, 9, 1, 0, 0);           chk("addu_r9", 6'b010010); tick();
    ds(0, 9, 0, 0, 0, 0);           chk("fwd_r9", 6'b010100); tick();
    wb(9, 0);                       chk("retire_r9", 6'b000000); tick();
    ds(0, 0, 0, 1, 0, 0);           chk("dest_r0", 6'b010010); tick();
    ds(0, 0, 0, 0, 0, 0); ds_rs_used = 1; chk("r0_untracked", 6'b010010); tick();
    ds(0, 0, 10, 1, 0, 0);          chk("cap_w1", 6'b010010); tick();
    ds(0, 0, 10, 1, 0, 0);          chk("cap_w2", 6'b010000); tick();
    ds(0, 0, 10, 1, 0, 0);          chk("cap_w3", 6'b010000); tick();
    ds(0, 0, 10, 1, 0, 0);          chk("cap_w4_stall", 6'b100000); tick();
    ds(0, 0, 10, 1, 0, 0); wb(10, 0); chk("cap_w4_wb", 6'b010000); tick();
    ds(0, 0, 10, 1, 0, 0);          chk("cap_still_3", 6'b100000); tick();
    for (int i = 0; i < 3; i++) begin wb(10, 0); chk("cap_drain", 6'b000000); tick(); end
    ds(0, 0, 11, 1, 0, 0);          chk("ser_w1", 6'b010010); tick();
    ds(0, 0, 12, 1, 0, 0);          chk("ser_w2", 6'b010000); tick();
    ds(0, 0, 0, 0, 0, 1);           chk("ser_out2", 6'b100000); tick();
    ds(0, 0, 0, 0, 0, 1); wb(11, 0); chk("ser_wb1", 6'b100000); tick();
    ds(0, 0, 0, 0, 0, 1); wb(12, 0); chk("ser_wb2", 6'b100000); tick();
    ds(0, 0, 0, 0, 0, 1);           chk("ser_issue", 6'b010010); tick();
    for (int i = 0; i < 4; i++) begin
      ds(0, 0, 5'(13 + i), 1, 0, 0); chk("fl_write", i == 0 ? 6'b010010 : 6'b010000); tick();
    end
    ds(0, 0, 17, 1, 0, 0); flush = 1; chk("flush_issue", 6'b000000); tick();
    ds(13, 0, 0, 0, 0, 0);          chk("after_flush", 6'b010010); tick();
    wb(3, 0);                       chk("underflow", 6'b000010); tick();
    chk("err_set", 6'b000011); tick();
    flush = 1;                      chk("err_flush", 6'b000011); tick();
    ds(0, 0, 20, 1, 0, 0);          chk("err_sticky", 6'b010011); tick();
    reset = 1; #1;                  chk("async_reset", 6'b000010);
    tick();
    reset = 0;
    ds(0, 0, 21, 1, 0, 0);          chk("post_reset_issue", 6'b010010); tick();
    ds(21, 0, 0, 0, 0, 0);          chk("post_reset_track", 6'b011000); tick();
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Register-hazard scoreboard for the decode stage of the 5-stage MIPS pipeline. It tracks every in-flight GPR write between issue (ID→EX) and writeback (WB). From that state it produces the decode stall, so the combinational bypass network only handles forwardable results. It counts results that cannot be forwarded (loads, MFC0) separately from forwardable ones. It also serializes TLB/CACHE instructions by holding them until the pipeline is empty, and clears all state on pipeline flush.

## Interface
- NUM_REGS, 32, number of GPRs tracked; r0 is never tracked.
- CNT_W, 2, per-register in-flight counter width; maximum of 3 outstanding writes per register.
- OUT_W, 3, width of the total in-flight counter; maximum of 7.

- clk  in  1  pipeline clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  exception/ERET flush; discards all in-flight tracking.
- ds_valid  in  1  decode stage holds a valid instruction.
- es_allowin  in  1  EX stage can accept an instruction.
- ds_rs / ds_rt  in  5  source register numbers.
- ds_rs_used / ds_rt_used  in  1  source operand is actually read (immediate-form rt is not read).
- ds_dest  in  5  destination register number.
- ds_dest_we  in  1  the instruction writes a GPR.
- ds_late  in  1  result is not forwardable before WB (load, MFC0).
- ds_serial  in  1  TLB/CACHE-class instruction; must issue into an empty pipeline.
- wb_valid  in  1  WB commits a register write this cycle.
- wb_dest  in  5  WB destination.
- wb_late  in  1  the committing write was issued with ds_late=1.
- ds_stall  out  1  hold the decode stage.
- ds_issue  out  1  ds_valid & es_allowin & ~ds_stall & ~flush.
- rs_inflight / rt_inflight  out  1  source has a forwardable in-flight producer; this is the bypass-select hint.
- sb_empty  out  1  total in-flight count is 0.
- sb_error  out  1  sticky; set on counter underflow or overflow.

## Operation
- State per register r in 1..31: pend_cnt[r] (CNT_W bits) counts all in-flight writes; late_cnt[r] (CNT_W bits) counts only late writes. A global out_cnt (OUT_W bits) counts all in-flight writes.
- Reset: all counters are 0 and sb_error=0. Outputs after reset: ds_stall=0 unless a serial condition applies, sb_empty=1, rs/rt_inflight=0.
- A write is tracked when ds_issue & ds_dest_we & ds_dest≠0. Its effect is pend_cnt[dest]+1, out_cnt+1, and late_cnt[dest]+1 if ds_late.
- A write is retired when wb_valid & wb_dest≠0. Its effect is pend_cnt[wb_dest]−1, out_cnt−1, and late_cnt[wb_dest]−1 if wb_late.
- Issue and retire on the same register in the same cycle: the net update is applied, so the counter stays unchanged when both hit the same counter.
- Effective late count for a source s: eff_late(s) = late_cnt[s] − (wb_valid & wb_late & wb_dest==s). WB data is forwardable, so a late write at WB does not stall.
- Stall terms:
  - src_hazard = (ds_rs_used & ds_rs≠0 & eff_late(rs)≠0) | (ds_rt_used & ds_rt≠0 & eff_late(rt)≠0).
  - cap_hazard = ds_dest_we & ds_dest≠0 & pend_cnt[ds_dest]==3 & ~(wb_valid & wb_dest==ds_dest).
  - serial_hazard = ds_serial & (out_cnt≠0 | wb_valid).
  - ds_stall = ds_valid & (src_hazard | cap_hazard | serial_hazard).
- rs_inflight = ds_rs≠0 & pend_cnt[ds_rs]≠0. rt_inflight is defined the same way on ds_rt.
- flush: on the next edge all counters go to 0. Any same-cycle issue or retire is discarded. ds_issue is forced to 0 while flush=1. sb_error is not cleared by flush.
- Error handling:
  - Retiring a register whose pend_cnt is 0 leaves the counters unchanged and sets sb_error.
  - A counter that would wrap past its maximum saturates and sets sb_error.
  - sb_error clears only on reset.

## Timing
- ds_stall, ds_issue, rs/rt_inflight and sb_empty are combinational from current state and inputs, with zero latency.
- Counter updates are visible in the cycle after the issue or retire edge.
- A load issued at cycle t, with a dependent instruction in decode at t+1: the dependent stalls until the load's wb_valid cycle, and issues in that cycle.
- The reset assertion clears state asynchronously, including in the middle of an operation. The first issue is accepted on the first edge after deassertion.

## Test plan
- Reset, then ds_valid=1, rs=5, rs_used=1, es_allowin=1 → ds_stall=0, ds_issue=1, sb_empty=1.
- Issue lw with dest=8 (ds_late=1), then addu with rs=8: addu stalls at t+1 and t+2. With wb_valid, wb_dest=8, wb_late=1 at t+3, expect ds_stall=0 and ds_issue=1 at t+3. Then late_cnt[8]=0.
- Issue addu with dest=9 (not late), then a reader of r9 → ds_stall=0, rt_inflight=1.
- Issue three writes to r10 without a retire, then a fourth write → ds_stall=1. Assert wb_valid with wb_dest=10 in the same cycle → ds_stall=0, and pend_cnt[10] stays at 3.
- Issue two writes (out_cnt=2), then ds_serial=1 → stall until both retire and wb_valid=0 → ds_issue=1.
- Issue 4 writes, then flush=1 together with an issue → next cycle sb_empty=1, no write tracked. wb_valid to r3 with pend_cnt=0 → sb_error=1 and stays 1 until reset.
